// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and constants for the fully-connected layer
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [2:0]  CSEL_FLAT = 3'b101;
    localparam logic [2:0]  CSEL_FC   = 3'b110;
    localparam int          FRAC_BITS = 16;
    localparam logic [19:0] SAT_MAX   = 20'h7FFFF;

endpackage

// File: rtl/fc_requant.sv
// rtl/fc_requant.sv - ReLU, round-half-up and saturate an x.32 accumulator to 4.16
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_W = 52
) (
    input  logic [ACC_W-1:0] acc,
    output logic [19:0]      score
);

    localparam int R_W = ACC_W - FRAC_BITS;

    logic [R_W-1:0] r;

    // Drop the 16 extra fraction bits and round half up; acc is non-negative
    // whenever r is used, so the add cannot overflow.
    assign r = acc[ACC_W-1:FRAC_BITS] + {{(R_W-1){1'b0}}, acc[FRAC_BITS-1]};

    // Negative sums clamp to zero, large positive sums clamp to the 4.16 maximum.
    always_comb begin
        score = r[19:0];
        if (acc[ACC_W-1]) begin
            score = 20'h0;
        end else if (r > {{(R_W-20){1'b0}}, SAT_MAX}) begin
            score = SAT_MAX;
        end
    end

endmodule

// File: rtl/fc_layer.sv
// rtl/fc_layer.sv - fully-connected classifier: dot products, bias, ReLU/requant
module fc_layer
    import fc_pkg::*;
#(
    parameter int N_IN      = 2048,
    parameter int NUM_OUT   = 10,
    parameter int DATA_W    = 20,
    parameter int ACC_W     = 52,
    parameter int WADDR_W   = 15,
    parameter int BIAS_BASE = N_IN * NUM_OUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    output logic               busy,
    output logic [2:0]         csel,
    output logic               crd,
    output logic [11:0]        caddr_rd,
    input  logic [DATA_W-1:0]  cdata_rd,
    output logic [WADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    output logic               cwr,
    output logic [11:0]        caddr_wr,
    output logic [19:0]        cdata_wr
);

    localparam int CNT_W = $clog2(N_IN);
    localparam int OUT_W = $clog2(NUM_OUT);

    state_t                    state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [OUT_W-1:0]          out_idx, out_idx_d;
    logic signed [ACC_W-1:0]   acc, acc_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic [19:0]                score;

    logic                busy_d, crd_d, cwr_d;
    logic [2:0]          csel_d;
    logic [11:0]         caddr_rd_d, caddr_wr_d;
    logic [19:0]         cdata_wr_d;
    logic [WADDR_W-1:0]  waddr_d;

    logic last_in, last_out;

    assign last_in  = (cnt == CNT_W'(N_IN - 1));
    assign last_out = (out_idx == OUT_W'(NUM_OUT - 1));

    // Full-precision 8.32 product, and the bias aligned to the x.32 accumulator.
    assign prod     = $signed(cdata_rd) * $signed(wdata);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){wdata[DATA_W-1]}}, wdata, {FRAC_BITS{1'b0}}};

    // Requantise the value the accumulator will hold on entry to WRITE.
    fc_requant #(.ACC_W(ACC_W)) u_requant (
        .acc   (acc_d),
        .score (score)
    );

    // State, counters, accumulator and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            out_idx  <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            csel     <= 3'b000;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            waddr    <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            out_idx  <= out_idx_d;
            acc      <= acc_d;
            busy     <= busy_d;
            crd      <= crd_d;
            cwr      <= cwr_d;
            csel     <= csel_d;
            caddr_rd <= caddr_rd_d;
            caddr_wr <= caddr_wr_d;
            cdata_wr <= cdata_wr_d;
            waddr    <= waddr_d;
        end
    end

    // Next state plus counter/accumulator updates; the first MAC cycle of each
    // output has no read data in flight yet, so it only issues an address.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        out_idx_d = out_idx;
        acc_d     = acc;
        case (state)
            IDLE: begin
                if (ready) begin
                    state_d   = MAC;
                    cnt_d     = '0;
                    out_idx_d = '0;
                    acc_d     = '0;
                end
            end
            MAC: begin
                if (cnt != '0) acc_d = acc + prod_ext;
                if (last_in) state_d = DRAIN;
                else         cnt_d   = cnt + 1'b1;
            end
            DRAIN: begin
                acc_d   = acc + prod_ext;
                state_d = BIAS;
            end
            BIAS: begin
                acc_d   = acc + bias_ext;
                state_d = WRITE;
            end
            WRITE: begin
                if (last_out) begin
                    state_d = DONE;
                end else begin
                    state_d   = MAC;
                    out_idx_d = out_idx + 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming state, so strobes line up with that state.
    always_comb begin
        busy_d     = (state_d != IDLE) && (state_d != DONE);
        crd_d      = (state_d == MAC);
        cwr_d      = (state_d == WRITE);
        csel_d     = 3'b000;
        caddr_rd_d = '0;
        caddr_wr_d = '0;
        cdata_wr_d = '0;
        waddr_d    = '0;
        case (state_d)
            MAC: begin
                csel_d     = CSEL_FLAT;
                caddr_rd_d = 12'(cnt_d);
                waddr_d    = WADDR_W'(int'(out_idx_d) * N_IN + int'(cnt_d));
            end
            DRAIN: begin
                waddr_d = WADDR_W'(BIAS_BASE + int'(out_idx_d));
            end
            WRITE: begin
                csel_d     = CSEL_FC;
                caddr_wr_d = 12'(out_idx_d);
                cdata_wr_d = score;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fc_layer.sv
// tb/tb_fc_layer.sv - scoreboard bench for fc_layer
module tb_fc_layer;

    localparam int N_IN    = 2048;
    localparam int NUM_OUT = 10;
    localparam int BBASE   = N_IN * NUM_OUT;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        busy;
    logic [2:0]  csel;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [14:0] waddr;
    logic [19:0] wdata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;

    logic [19:0] flat [0:4095];
    logic [19:0] rom  [0:32767];

    logic [31:0] sb [$];
    int total = 0;
    int bad   = 0;

    fc_layer dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .busy     (busy),
        .csel     (csel),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .waddr    (waddr),
        .wdata    (wdata),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flatten bank and weight ROM, both with one cycle of read latency.
    always @(posedge clk) begin
        cdata_rd <= (crd && csel == 3'b101) ? flat[caddr_rd] : 20'h0;
        wdata    <= rom[waddr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write is popped against the scoreboard.
    always @(negedge clk) begin
        if (crd && cwr) chk("crd_cwr_overlap", 64'(crd & cwr), 64'd0);
        if (cwr) begin
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            chk("write_csel", 64'(csel), 64'h6);
            if (sb.size() != 0) begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("write_addr_data", 64'({caddr_wr, cdata_wr}), 64'(e));
            end
        end
    end

    task automatic push_exp(input int o, input logic [19:0] v);
        sb.push_back({12'(o), v});
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic fill(input logic [19:0] d, input logic [19:0] w);
        for (int i = 0; i < 4096; i++) flat[i] = (i < N_IN) ? d : 20'h0;
        for (int i = 0; i < 32768; i++) rom[i] = (i < BBASE) ? w : 20'h0;
    endtask

    // Counts busy-high samples from 1; checks first write and busy fall positions.
    task automatic run_check(input string tag);
        int t;
        int idx;
        int first;
        t = 0;
        while (!busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        idx   = 1;
        first = 0;
        while (busy && idx < 25000) begin
            if (cwr && first == 0) first = idx;
            @(negedge clk);
            idx++;
        end
        chk({tag, "_first_cwr"}, 64'(first), 64'd2051);
        chk({tag, "_busy_fall"}, 64'(idx), 64'd20511);
        chk({tag, "_all_writes"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int t;
        reset = 1'b0;
        ready = 1'b0;
        fill(20'h0, 20'h0);
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({busy, crd, cwr, csel}), 64'd0);
        chk("reset_addr", 64'({caddr_rd, caddr_wr, waddr}), 64'd0);
        chk("reset_wdata", 64'(cdata_wr), 64'd0);
        reset = 1'b1;

        // Bias-only pattern, first aborted by reset 500 cycles in.
        fill(20'h0, 20'h0);
        for (int o = 0; o < NUM_OUT; o++) rom[BBASE + o] = 20'h01000;
        pulse_ready();
        t = 0;
        while (!busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("abort_busy_rise", 64'(busy), 64'd1);
        repeat (500) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_strobes", 64'({crd, cwr, csel}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", 64'(busy), 64'd0);

        // Re-trigger with ready held high for the whole run.
        for (int o = 0; o < NUM_OUT; o++) push_exp(o, 20'h01000);
        ready = 1'b1;
        run_check("bias");
        t = 0;
        while (!busy && t < 5) begin
            @(negedge clk);
            t++;
        end
        chk("held_ready_restart", 64'(busy), 64'd1);
        ready = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_aborted", 64'(busy), 64'd0);

        // Unit accumulation on outputs 0-4, negative sum with bias on 5-9.
        fill(20'h10000, 20'h0);
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) rom[o*N_IN + i] = (o < 5) ? 20'h00010 : 20'hFFFF0;
            rom[BBASE + o] = (o < 5) ? 20'h0 : 20'h00100;
            push_exp(o, (o < 5) ? 20'h08000 : 20'h0);
        end
        pulse_ready();
        run_check("unit_relu");

        // Saturation.
        fill(20'h7FFFF, 20'h7FFFF);
        for (int o = 0; o < NUM_OUT; o++) push_exp(o, 20'h7FFFF);
        pulse_ready();
        run_check("sat");

        // Rounding: half rounds up, just under half rounds down.
        fill(20'h0, 20'h0);
        flat[0] = 20'h00001;
        for (int o = 0; o < NUM_OUT; o++) begin
            rom[o*N_IN] = (o % 2 == 0) ? 20'h08000 : 20'h07FFF;
            push_exp(o, (o % 2 == 0) ? 20'h00001 : 20'h0);
        end
        pulse_ready();
        run_check("round");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_layer.md
Name: fc_layer

Overview:
- Fully-connected classifier stage directly downstream of the convolution/max-pool engine.
- After that engine finishes, the flattened layer-1 data sits in local memory bank csel=3'b101: 2048 words, signed 20-bit, 4.16 fixed point.
- fc_layer computes NUM_OUT dot products of that vector against a weight ROM, adds a per-output bias, applies ReLU with rounding and saturation, and writes NUM_OUT scores to bank csel=3'b110.
- It uses the same ready/busy and csel/crd/cwr memory protocol as the rest of the datapath.

Parameters:
- N_IN, 2048, flattened input length; must be a power of two.
- NUM_OUT, 10, number of output neurons.
- DATA_W, 20, data/weight/bias width, signed 4.16.
- ACC_W, 52, accumulator width; must be at least 2*DATA_W + log2(N_IN) + 1.
- WADDR_W, 15, weight ROM address width.
- BIAS_BASE, N_IN*NUM_OUT, ROM address of bias[0]; bias[o] is at BIAS_BASE+o.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- ready  in  1  start request, sampled in IDLE only.
- busy  out  1  high from the cycle after start until the DONE cycle.
- csel  out  3  memory bank select: 3'b101 for reads, 3'b110 for writes, 0 otherwise.
- crd  out  1  read strobe.
- caddr_rd  out  12  read address into the flatten bank.
- cdata_rd  in  20  read data; valid the cycle after address and crd are presented.
- waddr  out  WADDR_W  weight ROM address.
- wdata  in  20  ROM data; one-cycle latency.
- cwr  out  1  write strobe.
- caddr_wr  out  12  write address, equal to the output index.
- cdata_wr  out  20  score to write.

Behaviour:
- Reset (reset=0, immediate): state IDLE; busy, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr and waddr all 0; acc=0; out_idx=0; cnt=0.
- Reset mid-operation aborts the operation with no partial write. After release the block waits in IDLE for a new ready.
- States and transitions:
  - IDLE: on ready=1, go to MAC with busy=1, acc=0, out_idx=0, cnt=0.
  - MAC: crd=1, csel=3'b101, caddr_rd=cnt, waddr=out_idx*N_IN+cnt. Each cycle: acc += sext(cdata_rd*wdata) for the address issued the previous cycle (none on the first MAC cycle of each output). When cnt=N_IN-1, go to DRAIN; otherwise cnt+1.
  - DRAIN (1 cycle): accumulate the last product; crd=0; waddr=BIAS_BASE+out_idx.
  - BIAS (1 cycle): acc += sext(wdata)<<<16.
  - WRITE (1 cycle): cwr=1, csel=3'b110, caddr_wr=out_idx, cdata_wr=requant(acc). If out_idx=NUM_OUT-1, go to DONE. Otherwise out_idx+1, acc=0, cnt=0, go to MAC.
  - DONE (1 cycle): busy=0, then IDLE.
- Strobes and addresses are registered outputs, aligned exactly with their state.
- Products are 40-bit signed in 8.32 format; acc is ACC_W signed in x.32 format. There is no intermediate truncation.
- requant(acc), in this order:
  - If acc<0, result 0 (ReLU).
  - Else r = acc[ACC_W-1:16] + acc[15] (round half up).
  - If r > 20'h7FFFF, result 20'h7FFFF (saturate); else result r[19:0].
- Latency: first cwr is N_IN+3 cycles after busy rises. Writes are N_IN+3 cycles apart. busy falls NUM_OUT*(N_IN+3)+1 cycles after rising.
- ready asserted while busy is ignored; ready held high through DONE starts a new run from IDLE.
- crd and cwr are never high in the same cycle. caddr_rd wraps only via the cnt clear.

Decomposition:
- fc_pkg holds:
  - the state enum (IDLE, MAC, DRAIN, BIAS, WRITE, DONE);
  - CSEL_FLAT=3'b101, CSEL_FC=3'b110;
  - FRAC_BITS=16 and SAT_MAX=20'h7FFFF.
- Sub-module fc_requant: purely combinational ReLU/round/saturate, ACC_W in and 20 bits out. It is reused by any later dense layer.
- The top level holds the FSM, counters and MAC.

Test Plan:
1. Latency and bias path: all data=0, bias[o]=20'h01000, ready pulse. Expect cwr at addresses 0..9, each cdata_wr=20'h01000. First cwr is at busy-rise+2051 cycles; busy falls at +20511.
2. Unit accumulation: data all 20'h10000, weights all 20'h00010, bias 0. Expect every output = 20'h08000.
3. ReLU: data all 20'h10000, weights all 20'hFFFF0, bias 20'h00100. Sum is negative, so expect every output = 0.
4. Rounding: data[0]=20'h00001, all others 0, weight[o*N_IN]=20'h08000, bias 0. Expect 20'h00001. With the weight set to 20'h07FFF, expect 0.
5. Saturation: data and weights all 20'h7FFFF. Expect every output = 20'h7FFFF.
6. Mid-run reset and re-trigger:
   - Drive reset=0 at cycle 500 after busy rises: busy, crd and cwr go to 0 immediately, and no write occurs.
   - Re-assert ready: the run restarts at output 0.
   - Holding ready high throughout a run does not restart it.
